// File: rtl/trace_buffer_pkg.sv
// Shared definitions for the retirement trace buffer: FSM state encodings
// and the packed trace record layout.
// Optional feature macro: TRACE_TIMESTAMP_EN adds a 32-bit cycle stamp to each record.
package trace_buffer_pkg;

  typedef enum logic [1:0] {
    TRACE_RUN   = 2'd0,
    TRACE_DRAIN = 2'd1,
    TRACE_DONE  = 2'd2
  } trace_state_e;

`ifdef TRACE_TIMESTAMP_EN
  localparam int TRACE_REC_W = 134;
`else
  localparam int TRACE_REC_W = 102;
`endif

  // One retired instruction as it sits in the FIFO.
  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] cycle;
`endif
    logic [31:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO used as trace storage. Pointers wrap naturally because
// DEPTH is a power of two. A push while full is accepted only when a pop
// happens in the same cycle; a pop while empty is ignored.
module trace_fifo #(
  parameter int WIDTH = 102,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem[rd_ptr_q];

  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Next pointer and occupancy values from the accepted push/pop pair.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !rd_en)      count_d = count_q + 1'b1;
    else if (!wr_en && rd_en) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; occupancy and pointers alone decide what is valid.
    if (wr_en) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/trace_buffer.sv
// Retirement trace buffer: captures retired instructions into a FIFO while
// the core runs, then drains after halt and reports done once empty.
// Optional feature macro: TRACE_TIMESTAMP_EN adds a free-running cycle
// counter and the out_cycle port carrying the stamp taken at push time.
module trace_buffer
  import trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   retire_valid,
  input  logic [31:0]            retire_pc,
  input  logic [31:0]            retire_inst,
  input  logic                   gpr_we,
  input  logic [4:0]             gpr_waddr,
  input  logic [31:0]            gpr_wdata,
  input  logic                   halt_sig,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_inst,
  output logic                   out_we,
  output logic [4:0]             out_waddr,
  output logic [31:0]            out_wdata,
`ifdef TRACE_TIMESTAMP_EN
  output logic [31:0]            out_cycle,
`endif
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            drop_count,
  output logic                   done
);

  localparam int CW = $clog2(DEPTH) + 1;

  trace_state_e state_q, state_d;
  logic         overflow_q, overflow_d;
  logic [15:0]  drop_count_q, drop_count_d;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]  cycle_q, cycle_d;
`endif

  trace_rec_t            rec_in, rec_out;
  logic [TRACE_REC_W-1:0] fifo_rdata;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  push_req, pop, drop, drain_empty;

  assign push_req = retire_valid && (state_q == TRACE_RUN);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = push_req && fifo_full && !pop;
  // During drain nothing is pushed, so the FIFO ends this cycle empty when
  // it already is, or when its last entry is being popped.
  assign drain_empty = (fifo_count == {{(CW-1){1'b0}}, pop});

  // Pack the retiring instruction; non-writing instructions carry no GPR data.
  always_comb begin
    rec_in       = '0;
    rec_in.pc    = retire_pc;
    rec_in.inst  = retire_inst;
    rec_in.we    = gpr_we;
    rec_in.waddr = gpr_we ? gpr_waddr : 5'd0;
    rec_in.wdata = gpr_we ? gpr_wdata : 32'd0;
`ifdef TRACE_TIMESTAMP_EN
    rec_in.cycle = cycle_q;
`endif
  end

  trace_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req && !drop),
    .pop   (pop),
    .wdata (rec_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head record is forced to zero while empty so reset shows clean outputs.
  assign rec_out   = out_valid ? trace_rec_t'(fifo_rdata) : '0;
  assign out_pc    = rec_out.pc;
  assign out_inst  = rec_out.inst;
  assign out_we    = rec_out.we;
  assign out_waddr = rec_out.waddr;
  assign out_wdata = rec_out.wdata;
`ifdef TRACE_TIMESTAMP_EN
  assign out_cycle = rec_out.cycle;
`endif

  assign count      = fifo_count;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign done       = (state_q == TRACE_DONE);

  // Next state, sticky overflow and saturating drop counter.
  always_comb begin
    state_d      = state_q;
    overflow_d   = overflow_q | drop;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
    unique case (state_q)
      TRACE_RUN:   if (halt_sig)    state_d = TRACE_DRAIN;
      TRACE_DRAIN: if (drain_empty) state_d = TRACE_DONE;
      TRACE_DONE:  state_d = TRACE_DONE;
      default:     state_d = TRACE_RUN;
    endcase
  end

`ifdef TRACE_TIMESTAMP_EN
  // Free-running cycle counter, wraps at 2^32.
  assign cycle_d = cycle_q + 32'd1;
`endif

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= TRACE_RUN;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
`ifdef TRACE_TIMESTAMP_EN
      cycle_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
`ifdef TRACE_TIMESTAMP_EN
      cycle_q      <= cycle_d;
`endif
    end
  end

endmodule

// File: tb/tb_trace_buffer.sv
// Directed self-checking bench for trace_buffer (DEPTH=16).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_trace_buffer;

  localparam int DEPTH = 16;
  localparam logic [31:0] ORI_INST = 32'h3401_1234; // ori $1,$0,0x1234

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_pc = '0;
  logic [31:0] retire_inst = '0;
  logic        gpr_we = 1'b0;
  logic [4:0]  gpr_waddr = '0;
  logic [31:0] gpr_wdata = '0;
  logic        halt_sig = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_inst, out_wdata;
  logic        out_we;
  logic [4:0]  out_waddr;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] out_cycle;
`endif
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_count;
  logic        done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc),
    .retire_inst  (retire_inst),
    .gpr_we       (gpr_we),
    .gpr_waddr    (gpr_waddr),
    .gpr_wdata    (gpr_wdata),
    .halt_sig     (halt_sig),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_we       (out_we),
    .out_waddr    (out_waddr),
    .out_wdata    (out_wdata),
`ifdef TRACE_TIMESTAMP_EN
    .out_cycle    (out_cycle),
`endif
    .count        (count),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .done         (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    retire_valid = 1'b0;
    out_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic set_retire(input logic v, input logic [31:0] pc, input logic we,
                            input logic [4:0] wa, input logic [31:0] wd);
    retire_valid = v;
    retire_pc    = pc;
    retire_inst  = ORI_INST;
    gpr_we       = we;
    gpr_waddr    = wa;
    gpr_wdata    = wd;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop", drop_count, 0);
    check("rst_done", done, 0);
    check("rst_pc", out_pc, 0);
    check("rst_wdata", out_wdata, 0);

    // Three retires held, then drained in order
    for (int i = 0; i < 3; i++) begin
      set_retire(1'b1, 32'h3000 + 32'(4*i), 1'b1, 5'd1, 32'h1234);
      step();
    end
    set_retire(1'b0, '0, 1'b0, '0, '0);
    check("hold_count", count, 3);
    check("hold_pc", out_pc, 32'h3000);
    check("hold_inst", out_inst, ORI_INST);
    check("hold_waddr", out_waddr, 1);
    check("hold_wdata", out_wdata, 32'h1234);
    step(); step();
    check("hold_stable_pc", out_pc, 32'h3000);
    check("hold_stable_count", count, 3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain3_valid", out_valid, 1);
      check("drain3_pc", out_pc, 32'h3000 + 32'(4*i));
      step();
    end
    check("drain3_empty", out_valid, 0);
    out_ready = 1'b0;

    // Non-writing instruction stores zero GPR fields
    set_retire(1'b1, 32'h3100, 1'b0, 5'd5, 32'hDEAD_BEEF);
    step();
    set_retire(1'b0, '0, 1'b0, '0, '0);
    check("nowe_we", out_we, 0);
    check("nowe_waddr", out_waddr, 0);
    check("nowe_wdata", out_wdata, 0);
    check("nowe_pc", out_pc, 32'h3100);

    // Overflow: 20 retires into 16 entries
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_retire(1'b1, 32'h4000 + 32'(4*i), 1'b1, 5'd2, 32'(i));
      step();
    end
    set_retire(1'b0, '0, 1'b0, '0, '0);
    check("ovf_count", count, 16);
    check("ovf_flag", overflow, 1);
    check("ovf_drop", drop_count, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_drain_pc", out_pc, 32'h4000 + 32'(4*i));
      check("ovf_drain_wdata", out_wdata, 32'(i));
      step();
    end
    check("ovf_drain_empty", out_valid, 0);
    check("ovf_sticky", overflow, 1);
    out_ready = 1'b0;

    // Full FIFO with simultaneous push and pop, including pointer wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_retire(1'b1, 32'h5000 + 32'(4*i), 1'b1, 5'd3, 32'(i));
      step();
    end
    out_ready = 1'b1;
    for (int i = 16; i < 26; i++) begin
      set_retire(1'b1, 32'h5000 + 32'(4*i), 1'b1, 5'd3, 32'(i));
      check("full_pp_head", out_pc, 32'h5000 + 32'(4*(i-16)));
      check("full_pp_count", count, 16);
      step();
    end
    set_retire(1'b0, '0, 1'b0, '0, '0);
    check("full_pp_count_end", count, 16);
    check("full_pp_overflow", overflow, 0);
    check("full_pp_drop", drop_count, 0);
    for (int k = 10; k < 26; k++) begin
      check("full_pp_order", out_pc, 32'h5000 + 32'(4*k));
      step();
    end
    check("full_pp_empty", out_valid, 0);
    out_ready = 1'b0;

    // Halt with a retire the same cycle, then drain to done
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_retire(1'b1, 32'h6000 + 32'(4*i), 1'b1, 5'd4, 32'(i));
      step();
    end
    halt_sig = 1'b1;
    set_retire(1'b1, 32'h6014, 1'b1, 5'd4, 32'd5);
    step();
    check("halt_count", count, 6);
    set_retire(1'b1, 32'h7000, 1'b1, 5'd4, 32'd9);
    step(); step();
    set_retire(1'b0, '0, 1'b0, '0, '0);
    check("halt_ignored", count, 6);
    check("halt_done_early", done, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("halt_drain_pc", out_pc, 32'h6000 + 32'(4*i));
      check("halt_drain_done", done, 0);
      step();
    end
    check("halt_done", done, 1);
    check("halt_final_count", count, 0);
    set_retire(1'b1, 32'h7100, 1'b1, 5'd4, 32'd1);
    step(); step();
    set_retire(1'b0, '0, 1'b0, '0, '0);
    check("done_held", done, 1);
    check("done_no_push", count, 0);
    out_ready = 1'b0;

    // Reset in the middle of drain
    halt_sig = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_retire(1'b1, 32'h8000 + 32'(4*i), 1'b1, 5'd6, 32'(i));
      step();
    end
    set_retire(1'b0, '0, 1'b0, '0, '0);
    halt_sig = 1'b1;
    step();
    halt_sig = 1'b0;
    check("mid_state_drain", 64'(dut.state_q), 64'(trace_buffer_pkg::TRACE_DRAIN));
    check("mid_count", count, 4);
    do_reset();
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_state", 64'(dut.state_q), 64'(trace_buffer_pkg::TRACE_RUN));
    set_retire(1'b1, 32'h8100, 1'b1, 5'd6, 32'd7);
    step();
    set_retire(1'b0, '0, 1'b0, '0, '0);
    check("mid_rst_run_push", count, 1);

    // Reset with halt still high re-enters drain, then done with empty FIFO
    halt_sig = 1'b1;
    do_reset();
    check("rehalt_state_run", 64'(dut.state_q), 64'(trace_buffer_pkg::TRACE_RUN));
    step();
    check("rehalt_state_drain", 64'(dut.state_q), 64'(trace_buffer_pkg::TRACE_DRAIN));
    check("rehalt_done0", done, 0);
    step();
    check("rehalt_done1", done, 1);
    halt_sig = 1'b0;

`ifdef TRACE_TIMESTAMP_EN
    // Timestamps captured at push time
    do_reset();
    repeat (5) step();
    set_retire(1'b1, 32'h9000, 1'b1, 5'd7, 32'd1);
    step();
    set_retire(1'b0, '0, 1'b0, '0, '0);
    repeat (3) step();
    set_retire(1'b1, 32'h9004, 1'b1, 5'd7, 32'd2);
    step();
    set_retire(1'b0, '0, 1'b0, '0, '0);
    check("ts_first", out_cycle, 5);
    out_ready = 1'b1;
    step();
    check("ts_second", out_cycle, 9);
    out_ready = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entry count, a power of 2 and at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port retire_valid, input, 1 bit: one instruction retires this cycle.
REQ-005 SHALL have port retire_pc, input, 32 bits: PC of the retiring instruction.
REQ-006 SHALL have port retire_inst, input, 32 bits: instruction word.
REQ-007 SHALL have port gpr_we, input, 1 bit: the retiring instruction writes a GPR.
REQ-008 SHALL have port gpr_waddr, input, 5 bits: GPR write address.
REQ-009 SHALL have port gpr_wdata, input, 32 bits: GPR write data.
REQ-010 SHALL have port halt_sig, input, 1 bit: core halt, level.
REQ-011 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): the drain handshake.
REQ-012 SHALL have ports out_pc (32 bits), out_inst (32 bits), out_we (1 bit), out_waddr (5 bits) and out_wdata (32 bits), all outputs: the head record.
REQ-013 SHALL have port count, output, log2(DEPTH)+1 bits: entries held.
REQ-014 SHALL have ports overflow (output, 1 bit, sticky) and drop_count (output, 16 bits, saturating).
REQ-015 SHALL have port done, output, 1 bit: halt seen and FIFO fully drained.

Function
REQ-016 SHALL implement states RUN, DRAIN and DONE.
- RUN to DRAIN: halt_sig=1 sampled.
- DRAIN to DONE: count reaches 0.
- DONE: held until reset.
REQ-017 In RUN, retire_valid=1 SHALL push {pc, inst, we, waddr, wdata}; the record is visible on out_* no earlier than the next cycle.
REQ-018 When gpr_we=0, a pushed record SHALL store waddr=0 and wdata=0.
REQ-019 Pop SHALL occur when out_valid && out_ready.
- out_valid = (count != 0).
- out_* SHALL stay stable while out_valid && !out_ready.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged and be legal when full; when empty, the push SHALL NOT be popped in the same cycle.
REQ-021 A push while full without a concurrent pop SHALL:
- drop the record;
- set overflow;
- increment drop_count, saturating at 16'hFFFF.
REQ-022 In DRAIN and DONE, retire_valid SHALL be ignored; pops continue.
REQ-023 A retire in the same cycle halt_sig first rises SHALL still be pushed (the halting instruction is traced).
REQ-024 done SHALL assert in the cycle after the DRAIN-to-DONE transition condition is met, combinationally equal to (state==DONE).
REQ-025 Read/write pointers SHALL wrap modulo DEPTH with no bubble.

Reset
REQ-026 On reset=1 at a clk edge, the block SHALL clear:
- state=RUN, pointers=0, count=0, out_valid=0;
- overflow=0, drop_count=0, done=0;
- out_* data=0.
REQ-027 Reset mid-DRAIN SHALL discard all entries; halt_sig still high after reset SHALL re-enter DRAIN on the next edge.
REQ-028 FIFO storage array SHALL NOT require reset.

Configuration
REQ-029 Macro TRACE_TIMESTAMP_EN, when defined, SHALL:
- add a 32-bit free-running cycle counter (reset 0, wraps);
- add a 32-bit output out_cycle carrying the counter value at push time.
REQ-030 Without TRACE_TIMESTAMP_EN, the counter and out_cycle SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Shared defines header SHALL hold:
- the trace state encodings (TRACE_RUN=2'd0, TRACE_DRAIN=2'd1, TRACE_DONE=2'd2);
- the record-width constant (102 bits, or 134 with the timestamp).
REQ-032 Storage SHALL be a sub-module trace_fifo (parameterised width/depth, push/pop/full/empty/count); trace_buffer holds the FSM, overflow logic and record packing.

Verification
REQ-033 Reset, then 3 retires (pc 0x3000/0x3004/0x3008, ori $1 wdata 0x1234), out_ready=0 -> count=3, out_pc=0x3000 stable; then out_ready=1 -> pops in order over 3 cycles, out_valid=0 after.
REQ-034 DEPTH=16, out_ready=0, 20 retires -> count=16, overflow=1, drop_count=4; entries 0-15 drained intact.
REQ-035 Full FIFO, out_ready=1 and retire_valid=1 every cycle for 10 cycles -> count stays 16, overflow stays 0, order preserved.
REQ-036 halt_sig=1 with a retire the same cycle, 5 entries held -> that retire is stored (6 entries), later retires ignored, done=1 exactly one cycle after the last pop.
REQ-037 Reset asserted in DRAIN with 4 entries -> next cycle count=0, out_valid=0, done=0, state=RUN.
REQ-038 With TRACE_TIMESTAMP_EN, retires at cycles 5 and 9 after reset -> out_cycle 5 then 9.
